// File: rtl/writeback_pkg.sv
// Shared definitions for the register-file write-back controller.
//   - Source-code constants for the write-back source mux selector.
//   - FSM state encoding (wb_state_e), also used by the debug state output.
//   - classify_src(): maps a 4-bit source code to how the controller must
//     wait before writing (immediate, multiply/divide, shifter, memory) or
//     flags it as illegal.
package writeback_pkg;

  localparam logic [3:0] SRC_LINK   = 4'd0;
  localparam logic [3:0] SRC_FLAG   = 4'd1;
  localparam logic [3:0] SRC_SHIFT  = 4'd2;
  localparam logic [3:0] SRC_HI     = 4'd3;
  localparam logic [3:0] SRC_LO     = 4'd5;
  localparam logic [3:0] SRC_MDR    = 4'd6;
  localparam logic [3:0] SRC_ALUOUT = 4'd7;
  localparam logic [3:0] SRC_BH     = 4'd8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_SRC = 3'd1,
    LATCH    = 3'd2,
    WRITE    = 3'd3,
    FAULT    = 3'd4
  } wb_state_e;

  typedef enum logic [2:0] {
    CLS_IMM        = 3'd0,
    CLS_WAIT_MD    = 3'd1,
    CLS_WAIT_SHIFT = 3'd2,
    CLS_WAIT_MEM   = 3'd3,
    CLS_ILLEGAL    = 3'd4
  } src_class_e;

  function automatic src_class_e classify_src(input logic [3:0] src);
    src_class_e cls;
    case (src)
      SRC_LINK, SRC_FLAG, SRC_ALUOUT: cls = CLS_IMM;
      SRC_HI, SRC_LO:                 cls = CLS_WAIT_MD;
      SRC_SHIFT:                      cls = CLS_WAIT_SHIFT;
      SRC_MDR, SRC_BH:                cls = CLS_WAIT_MEM;
      default:                        cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/writeback_ctrl_if.sv
// Write-back request handshake between the control-unit FSM (master) and
// the write-back controller (slave).
//   req_valid : master presents a request
//   req_ready : slave can accept this cycle
//   req_src   : 4-bit write-back source code
//   req_rd    : 5-bit destination register index
// Handshake: a request transfers on a rising clock edge where
// req_valid && req_ready; req_src/req_rd are only meaningful while
// req_valid is high, and the master holds them until the transfer.
interface writeback_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_src;
  logic [4:0] req_rd;

  modport master (output req_valid, output req_src, output req_rd, input req_ready);
  modport slave  (input req_valid, input req_src, input req_rd, output req_ready);
endinterface

// File: rtl/wb_timeout_ctr.sv
// Wait-state timeout counter for the write-back controller.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : zero the count (asserted when a request is accepted)
//   enable       : count one cycle (asserted while waiting for a source)
//   expired      : count has reached LIMIT; the counter saturates there
// Requires 2**TW > LIMIT.
module wb_timeout_ctr #(
  parameter int LIMIT = 64,
  parameter int TW    = 7
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TW-1:0] count;

  assign expired = (count == TW'(LIMIT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + TW'(1);
    end
  end

endmodule

// File: rtl/writeback_ctrl.sv
// Register-file write-back sequencing controller.
// Accepts one request at a time, drives the write-back source selector,
// waits for the chosen source to hold valid data, then issues a one-cycle
// register write (suppressed for r0).
// Optional build macro: WB_TIMEOUT_EN adds a wait-state timeout that aborts
// a stuck request with err after TIMEOUT_CYCLES cycles in WAIT_SRC.
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   req (slave)      : request handshake (req_valid/req_ready/req_src/req_rd)
//   flush            : abort a request still waiting (WAIT_SRC/LATCH)
//   md_busy          : HI/LO not yet valid
//   shift_done       : shift result valid (level)
//   mem_rdata_valid  : memory read data valid (level)
//   mdr_load         : one-cycle MDR latch strobe
//   mem_to_reg_sel   : source mux selector, held from acceptance to acceptance
//   reg_write        : one-cycle register-file write enable
//   wb_rd            : destination index qualifying reg_write
//   done / err       : one-cycle retire / fault pulses
//   state_dbg        : current FSM state
module writeback_ctrl
  import writeback_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TW             = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  writeback_ctrl_if.slave  req,
  input  logic             flush,
  input  logic             md_busy,
  input  logic             shift_done,
  input  logic             mem_rdata_valid,
  output logic             mdr_load,
  output logic [3:0]       mem_to_reg_sel,
  output logic             reg_write,
  output logic [4:0]       wb_rd,
  output logic             done,
  output logic             err,
  output wb_state_e        state_dbg
);

  if (TIMEOUT_CYCLES >= (1 << TW)) begin : g_tw_check
    $error("TW is too narrow to count to TIMEOUT_CYCLES");
  end

  wb_state_e  state;
  src_class_e req_cls;
  src_class_e held_cls;
  logic       accept;
  logic       src_ok;
  logic       timed_out;

  assign state_dbg = state;
  // Ready depends on flush only, never on the request inputs.
  assign req.req_ready = (state == IDLE) && !flush;
  assign accept        = req.req_valid && req.req_ready;
  assign req_cls       = classify_src(req.req_src);
  // The held selector doubles as the record of what we are waiting for.
  assign held_cls      = classify_src(mem_to_reg_sel);

  always_comb begin
    src_ok = 1'b0;
    case (held_cls)
      CLS_WAIT_MD:    src_ok = !md_busy;
      CLS_WAIT_SHIFT: src_ok = shift_done;
      CLS_WAIT_MEM:   src_ok = mem_rdata_valid;
      default:        src_ok = 1'b0;
    endcase
  end

`ifdef WB_TIMEOUT_EN
  wb_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES),
    .TW    (TW)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (accept),
    .enable  (state == WAIT_SRC),
    .expired (timed_out)
  );
`else
  assign timed_out = 1'b0;
`endif

  // Strobe outputs are registered: they are set on the transition into the
  // state they belong to, so each is high exactly while in that state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      mem_to_reg_sel <= 4'b0000;
      wb_rd          <= 5'd0;
      mdr_load       <= 1'b0;
      reg_write      <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      mdr_load  <= 1'b0;
      reg_write <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            mem_to_reg_sel <= req.req_src;
            wb_rd          <= req.req_rd;
            case (req_cls)
              CLS_IMM: begin
                state     <= WRITE;
                reg_write <= (req.req_rd != 5'd0);
                done      <= 1'b1;
              end
              CLS_ILLEGAL: begin
                state <= FAULT;
                err   <= 1'b1;
              end
              default: state <= WAIT_SRC;
            endcase
          end
        end
        WAIT_SRC: begin
          if (flush) begin
            state <= IDLE;
          end else if (src_ok) begin
            // A ready source wins over a timeout expiring the same cycle.
            if (held_cls == CLS_WAIT_MEM) begin
              state    <= LATCH;
              mdr_load <= 1'b1;
            end else begin
              state     <= WRITE;
              reg_write <= (wb_rd != 5'd0);
              done      <= 1'b1;
            end
          end else if (timed_out) begin
            state <= FAULT;
            err   <= 1'b1;
          end
        end
        LATCH: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            state     <= WRITE;
            reg_write <= (wb_rd != 5'd0);
            done      <= 1'b1;
          end
        end
        WRITE:   state <= IDLE;
        FAULT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_ctrl.sv
// Bench for writeback_ctrl: directed timing scenarios plus randomised
// requests. Retirements (done/err) are predicted into a queue at request
// time and popped by a monitor when the controller retires a request.
module tb_writeback_ctrl;
  import writeback_pkg::*;

  localparam int TO_CYCLES = 8;
  localparam int K_IMM = 0, K_WAIT = 1, K_SHIFT = 2, K_MEM = 3, K_ILL = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  writeback_ctrl_if bi ();
  logic       flush = 1'b0;
  logic       md_busy = 1'b0;
  logic       shift_done = 1'b0;
  logic       mem_rdata_valid = 1'b0;
  logic       mdr_load;
  logic [3:0] sel;
  logic       reg_write;
  logic [4:0] wb_rd;
  logic       done;
  logic       err;
  wb_state_e  st;

  writeback_ctrl #(.TIMEOUT_CYCLES(TO_CYCLES), .TW(4)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req             (bi),
    .flush           (flush),
    .md_busy         (md_busy),
    .shift_done      (shift_done),
    .mem_rdata_valid (mem_rdata_valid),
    .mdr_load        (mdr_load),
    .mem_to_reg_sel  (sel),
    .reg_write       (reg_write),
    .wb_rd           (wb_rd),
    .done            (done),
    .err             (err),
    .state_dbg       (st)
  );

  // ---------------- scoreboard ----------------
  // Entry: {err, reg_write, done, wb_rd[4:0], sel[3:0]}
  logic [11:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int tb_kind(input logic [3:0] src);
    case (src)
      4'd0, 4'd1, 4'd7: return K_IMM;
      4'd3, 4'd5:       return K_WAIT;
      4'd2:             return K_SHIFT;
      4'd6, 4'd8:       return K_MEM;
      default:          return K_ILL;
    endcase
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      if (done || err) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_retire", {30'd0, done, err}, 32'd0);
        end else begin
          check_val("retire", {20'd0, err, reg_write, done, wb_rd, sel}, {20'd0, exp_q.pop_front()});
        end
      end else if (reg_write) begin
        check_val("stray_write", {31'd0, reg_write}, 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge (cycle 0); returns at the falling edge of cycle 1.
  task automatic accept(input logic [3:0] src, input logic [4:0] rd, input bit retire);
    int k;
    k = tb_kind(src);
    bi.req_valid = 1'b1;
    bi.req_src   = src;
    bi.req_rd    = rd;
    #1;
    check_val("req_ready", {31'd0, bi.req_ready}, 32'd1);
    if (retire) begin
      if (k == K_ILL) exp_q.push_back({1'b1, 1'b0, 1'b0, rd, src});
      else            exp_q.push_back({1'b0, (rd != 5'd0), 1'b1, rd, src});
    end
    @(negedge clk);
    bi.req_valid = 1'b0;
    bi.req_src   = $urandom_range(0, 15);
    bi.req_rd    = $urandom_range(0, 31);
  endtask

  // Full request with its source becoming valid d cycles after cycle 1.
  task automatic run_req(input logic [3:0] src, input logic [4:0] rd, input int d);
    int k, lat, exp_lat;
    bit mdr_seen;
    k = tb_kind(src);
    md_busy = 1'b1; shift_done = 1'b0; mem_rdata_valid = 1'b0;
    accept(src, rd, 1'b1);
    if (k == K_IMM || k == K_ILL) exp_lat = 1;
    else if (k == K_MEM)          exp_lat = d + 3;
    else                          exp_lat = d + 2;
    lat = 1;
    mdr_seen = 1'b0;
    while (lat < 40) begin
      if (lat == 1 + d) begin
        if (k == K_WAIT)  md_busy = 1'b0;
        if (k == K_SHIFT) shift_done = 1'b1;
        if (k == K_MEM)   mem_rdata_valid = 1'b1;
      end
      #1;
      if (mdr_load) mdr_seen = 1'b1;
      if (done || err) break;
      @(negedge clk);
      lat++;
    end
    check_val("latency", 32'(lat), 32'(exp_lat));
    check_val("mdr_load_seen", {31'd0, mdr_seen}, {31'd0, (k == K_MEM)});
    md_busy = 1'b0; shift_done = 1'b0; mem_rdata_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bi.req_valid = 1'b0;
    bi.req_src   = 4'd0;
    bi.req_rd    = 5'd0;

    // Reset values
    repeat (2) @(negedge clk);
    check_val("rst_ready", {31'd0, bi.req_ready}, 32'd1);
    check_val("rst_sel", {28'd0, sel}, 32'd0);
    check_val("rst_rd", {27'd0, wb_rd}, 32'd0);
    check_val("rst_strobes", {28'd0, mdr_load, reg_write, done, err}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Immediate ALUOut to r5
    accept(4'd7, 5'd5, 1'b1);
    check_val("imm_write", {31'd0, reg_write}, 32'd1);
    check_val("imm_done", {31'd0, done}, 32'd1);
    check_val("imm_rd", {27'd0, wb_rd}, 32'd5);
    check_val("imm_sel", {28'd0, sel}, 32'd7);
    @(negedge clk);
    check_val("imm_c2_strobes", {30'd0, reg_write, done}, 32'd0);
    check_val("imm_c2_ready", {31'd0, bi.req_ready}, 32'd1);

    // MDR: data valid during cycle 4 -> mdr_load cycle 5, write cycle 6
    accept(4'd6, 5'd9, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      if (c == 4) mem_rdata_valid = 1'b1;
      #1;
      check_val("mdr_sel", {28'd0, sel}, 32'd6);
      check_val("mdr_load", {31'd0, mdr_load}, {31'd0, (c == 5)});
      check_val("mdr_write", {30'd0, reg_write, done}, (c == 6) ? 32'd3 : 32'd0);
      if (c < 6) @(negedge clk);
    end
    mem_rdata_valid = 1'b0;
    @(negedge clk);

    // HI with md busy, flushed at cycle 6
    md_busy = 1'b1;
    accept(4'd3, 5'd12, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      if (c == 6) flush = 1'b1;
      if (c == 7) flush = 1'b0;
      #1;
      if (c == 7) begin
        check_val("flush_idle", 32'(st), 32'(IDLE));
        check_val("flush_ready", {31'd0, bi.req_ready}, 32'd1);
      end
      check_val("flush_sel", {28'd0, sel}, 32'd3);
      check_val("flush_no_retire", {30'd0, reg_write, done}, 32'd0);
      @(negedge clk);
    end
    md_busy = 1'b0;
    repeat (2) @(negedge clk);

    // Illegal codes back to back
    accept(4'd4, 5'd3, 1'b1);
    check_val("ill4_err", {31'd0, err}, 32'd1);
    check_val("ill4_ready", {31'd0, bi.req_ready}, 32'd0);
    @(negedge clk);
    accept(4'd12, 5'd7, 1'b1);
    check_val("ill12_err", {31'd0, err}, 32'd1);
    check_val("ill12_no_write", {31'd0, reg_write}, 32'd0);
    @(negedge clk);

    // Shift source that never becomes valid
    shift_done = 1'b0;
`ifdef WB_TIMEOUT_EN
    exp_q.push_back({1'b1, 1'b0, 1'b0, 5'd4, 4'd2});
    accept(4'd2, 5'd4, 1'b0);
    lat = 1;
    while (!err && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_val("timeout_latency", 32'(lat), 32'(TO_CYCLES + 2));
    repeat (5) @(negedge clk);
    check_val("timeout_idle", 32'(st), 32'(IDLE));
`else
    accept(4'd2, 5'd4, 1'b0);
    repeat (100) @(negedge clk);
    check_val("wait_forever", 32'(st), 32'(WAIT_SRC));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_val("wait_flushed", 32'(st), 32'(IDLE));
`endif
    @(negedge clk);

    // Write to r0: done without reg_write
    accept(4'd0, 5'd0, 1'b1);
    check_val("r0_done", {31'd0, done}, 32'd1);
    check_val("r0_no_write", {31'd0, reg_write}, 32'd0);
    @(negedge clk);

    // Reset in the middle of a LO request
    md_busy = 1'b1;
    accept(4'd5, 5'd8, 1'b0);
    @(negedge clk);
    check_val("pre_reset_wait", 32'(st), 32'(WAIT_SRC));
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_val("mid_rst_state", 32'(st), 32'(IDLE));
    check_val("mid_rst_sel", {28'd0, sel}, 32'd0);
    check_val("mid_rst_rd", {27'd0, wb_rd}, 32'd0);
    check_val("mid_rst_strobes", {28'd0, mdr_load, reg_write, done, err}, 32'd0);
    check_val("mid_rst_ready", {31'd0, bi.req_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    md_busy = 1'b0;
    repeat (4) @(negedge clk);
    check_val("post_rst_idle", 32'(st), 32'(IDLE));

    // Randomised requests
    for (int i = 0; i < 40; i++) begin
      run_req(4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    check_val("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
